// File: rtl/nios_cpu_mul_pkg.sv
// Shared types and helpers for the Nios M-stage multiply back end.
package nios_cpu_mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULXUU = 2'd1,
    MULXSS = 2'd2,
    MULXSU = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HH   = 2'd1,
    FIX  = 2'd2
  } mul_state_t;

  localparam int unsigned HALF_W = 16;

  // Counter must hold the full step count 16/hh_bits, not just count below it.
  function automatic int unsigned hh_cnt_w(input int unsigned hh_bits);
    return $clog2(HALF_W / hh_bits + 1);
  endfunction

endpackage

// File: rtl/nios_cpu_mul_hh_iter.sv
// Iterative 16x16 unsigned multiplier: retires HH_BITS multiplier bits per cycle, MSB first.
module nios_cpu_mul_hh_iter
  import nios_cpu_mul_pkg::*;
#(
  parameter int unsigned HH_BITS = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        done_o,
  output logic [31:0] product_o
);

  localparam int unsigned STEPS = HALF_W / HH_BITS;
  localparam int unsigned CW    = hh_cnt_w(HH_BITS);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic [31:0]        acc_q, acc_d;
  logic [HH_BITS-1:0] digit;
  logic [31:0]        partial;

  always_comb begin
    digit   = b_q[15 -: HH_BITS];
    partial = '0;
    for (int unsigned i = 0; i < HH_BITS; i++) begin
      if (digit[i]) partial = partial + ({16'h0000, a_q} << i);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (start_i) begin
      cnt_d = CW'(STEPS);
      a_d   = a_i;
      b_d   = b_i;
      acc_d = '0;
    end else if (cnt_q != '0) begin
      acc_d = (acc_q << HH_BITS) + partial;
      b_d   = b_q << HH_BITS;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  // High during the cycle whose closing edge performs the final step.
  assign done_o    = (cnt_q == CW'(1));
  assign product_o = acc_q;

endmodule

// File: rtl/nios_cpu_mul_combine.sv
// Nios M-stage multiply back end: sums partial products for MUL, iterates a_hi*b_hi for MULX*.
module nios_cpu_mul_combine
  import nios_cpu_mul_pkg::*;
#(
  parameter int unsigned HH_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_en,
  input  logic        M_valid,
  input  logic [1:0]  M_op,
  input  logic [31:0] M_src1,
  input  logic [31:0] M_src2,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  input  logic        M_kill,
  output logic        M_mul_stall,
  output logic [31:0] W_mul_result,
  output logic        W_mul_valid
);

  mul_state_t  state_q, state_d;
  mul_op_t     op_q, op_d;
  mul_op_t     op_in;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [17:0] side_q, side_d;
  logic [31:0] res_q, res_d;
  logic        valid_q, valid_d;

  logic        accept;
  logic        hh_start;
  logic        hh_done;
  logic [31:0] hh_prod;
  logic [31:0] mid_sum;
  logic [31:0] mul_lo;
  logic [17:0] mid_w;
  logic [17:0] side_w;
  logic [31:0] hi_u;
  logic [31:0] corr_a;
  logic [31:0] corr_b;
  logic [31:0] hi_w;

  assign op_in  = mul_op_t'(M_op);
  assign accept = M_valid & M_en & ~M_kill & (state_q == IDLE);

  assign mid_sum = M_mul_cell_p2 + M_mul_cell_p3;
  assign mul_lo  = M_mul_cell_p1 + {mid_sum[15:0], 16'h0000};

  // mid carries out of bit 31 of the low word; side is everything above it except hh.
  assign mid_w  = {2'b00, M_mul_cell_p1[31:16]} + {2'b00, M_mul_cell_p2[15:0]}
                + {2'b00, M_mul_cell_p3[15:0]};
  assign side_w = {2'b00, M_mul_cell_p2[31:16]} + {2'b00, M_mul_cell_p3[31:16]}
                + {16'h0000, mid_w[17:16]};

  assign hi_u   = hh_prod + {14'h0000, side_q};
  assign corr_a = (a_q[31] && (op_q != MULXUU)) ? b_q : '0;
  assign corr_b = (b_q[31] && (op_q == MULXSS)) ? a_q : '0;
  assign hi_w   = hi_u - corr_a - corr_b;

  nios_cpu_mul_hh_iter #(
    .HH_BITS (HH_BITS)
  ) u_hh_iter (
    .clk_i     (clk),
    .rst_i     (reset),
    .start_i   (hh_start),
    .a_i       (M_src1[31:16]),
    .b_i       (M_src2[31:16]),
    .done_o    (hh_done),
    .product_o (hh_prod)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    side_d   = side_q;
    res_d    = res_q;
    valid_d  = 1'b0;
    hh_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_in == MUL) begin
            res_d   = mul_lo;
            valid_d = 1'b1;
          end else begin
            op_d     = op_in;
            a_d      = M_src1;
            b_d      = M_src2;
            side_d   = side_w;
            hh_start = 1'b1;
            state_d  = HH;
          end
        end
      end
      HH: begin
        if (M_kill)       state_d = IDLE;
        else if (hh_done) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (!M_kill) begin
          res_d   = hi_w;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MUL;
      a_q     <= '0;
      b_q     <= '0;
      side_q  <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      side_q  <= side_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign M_mul_stall  = (state_q != IDLE);
  assign W_mul_result = res_q;
  assign W_mul_valid  = valid_q;

endmodule

// File: tb/tb_nios_cpu_mul_combine.sv
// Directed bench for nios_cpu_mul_combine; three instances cover HH_BITS = 1, 2, 4.
module tb_nios_cpu_mul_combine;

  logic        clk = 1'b0;
  logic        reset;
  logic        M_en;
  logic        M_valid;
  logic [1:0]  op_r;
  logic [31:0] src1, src2;
  logic [31:0] p1, p2, p3;
  logic        M_kill;
  logic [2:0]  stall;
  logic [2:0]  valid;
  logic [31:0] res [3];

  int checks   = 0;
  int failures = 0;

  int          st_cnt   [3];
  int          vld_cnt  [3];
  int          vld_edge [3];
  logic [31:0] got      [3];
  logic [31:0] res_end  [3];
  logic        st_at5   [3];

  localparam int EXP_LAT [3] = '{17, 9, 5};

  always #5 clk = ~clk;

  // Multiply-cell model feeding the partial products.
  assign p1 = {16'h0000, src1[15:0]}  * {16'h0000, src2[15:0]};
  assign p2 = {16'h0000, src1[15:0]}  * {16'h0000, src2[31:16]};
  assign p3 = {16'h0000, src1[31:16]} * {16'h0000, src2[15:0]};

  nios_cpu_mul_combine #(.HH_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .M_en(M_en), .M_valid(M_valid), .M_op(op_r),
    .M_src1(src1), .M_src2(src2), .M_mul_cell_p1(p1), .M_mul_cell_p2(p2),
    .M_mul_cell_p3(p3), .M_kill(M_kill), .M_mul_stall(stall[0]),
    .W_mul_result(res[0]), .W_mul_valid(valid[0]));

  nios_cpu_mul_combine #(.HH_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .M_en(M_en), .M_valid(M_valid), .M_op(op_r),
    .M_src1(src1), .M_src2(src2), .M_mul_cell_p1(p1), .M_mul_cell_p2(p2),
    .M_mul_cell_p3(p3), .M_kill(M_kill), .M_mul_stall(stall[1]),
    .W_mul_result(res[1]), .W_mul_valid(valid[1]));

  nios_cpu_mul_combine #(.HH_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .M_en(M_en), .M_valid(M_valid), .M_op(op_r),
    .M_src1(src1), .M_src2(src2), .M_mul_cell_p1(p1), .M_mul_cell_p2(p2),
    .M_mul_cell_p3(p3), .M_kill(M_kill), .M_mul_stall(stall[2]),
    .W_mul_result(res[2]), .W_mul_valid(valid[2]));

  // Issue one op, then observe 30 cycles; k counts edges after the accept edge.
  task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic kill_on_accept, input int kill_at);
    src1 = a; src2 = b; op_r = op; M_valid = 1'b1; M_kill = kill_on_accept;
    @(posedge clk); #1;
    M_valid = 1'b0; M_kill = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st_cnt[i] = 0; vld_cnt[i] = 0; vld_edge[i] = -1; got[i] = '0; st_at5[i] = 1'b0;
    end
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (stall[i]) st_cnt[i]++;
        if (valid[i]) begin
          vld_cnt[i]++;
          if (vld_edge[i] < 0) begin vld_edge[i] = k; got[i] = res[i]; end
        end
        if (k == 5) st_at5[i] = stall[i];
      end
      M_kill = (k == kill_at);
      @(posedge clk); #1;
    end
    M_kill = 1'b0;
    for (int i = 0; i < 3; i++) res_end[i] = res[i];
  endtask

  task automatic test_reset();
    reset = 1'b1; M_en = 1'b1; M_valid = 1'b0; M_kill = 1'b0;
    op_r = 2'd0; src1 = '0; src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall[i] !== 1'b0 || valid[i] !== 1'b0 || res[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_state inst=%0d stall=%b valid=%b res=%h want 0/0/00000000",
                 i, stall[i], valid[i], res[i]);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_basic();
    drive_op(2'd0, 32'h00010003, 32'h00020005, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== 32'h000B000F || vld_edge[i] !== 0 || vld_cnt[i] !== 1) begin
        failures++;
        $display("FAIL mul_basic inst=%0d res=%h edge=%0d pulses=%0d want 000b000f/0/1",
                 i, got[i], vld_edge[i], vld_cnt[i]);
      end
      checks++;
      if (st_cnt[i] !== 0) begin
        failures++;
        $display("FAIL mul_no_stall inst=%0d stall_cycles=%0d want 0", i, st_cnt[i]);
      end
    end
  endtask

  task automatic test_mulx_cases();
    logic [1:0]  ops  [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    logic [31:0] va   [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010003};
    logic [31:0] vb   [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00020005};
    logic [31:0] vexp [4] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h00000002};
    for (int v = 0; v < 4; v++) begin
      drive_op(ops[v], va[v], vb[v], 1'b0, -1);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== vexp[v] || vld_cnt[i] !== 1) begin
          failures++;
          $display("FAIL mulx_result vec=%0d inst=%0d res=%h pulses=%0d want %h/1",
                   v, i, got[i], vld_cnt[i], vexp[v]);
        end
        checks++;
        if (st_cnt[i] !== EXP_LAT[i] || vld_edge[i] !== EXP_LAT[i]) begin
          failures++;
          $display("FAIL mulx_timing vec=%0d inst=%0d stall=%0d valid_edge=%0d want %0d/%0d",
                   v, i, st_cnt[i], vld_edge[i], EXP_LAT[i], EXP_LAT[i]);
        end
        checks++;
        if (res_end[i] !== vexp[v]) begin
          failures++;
          $display("FAIL mulx_hold vec=%0d inst=%0d res=%h want %h", v, i, res_end[i], vexp[v]);
        end
      end
    end
  endtask

  task automatic test_kill();
    drive_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vld_cnt[i] !== 0 || st_at5[i] !== 1'b0 || st_cnt[i] !== 5) begin
        failures++;
        $display("FAIL kill_in_hh inst=%0d pulses=%0d stall_k5=%b stall=%0d want 0/0/5",
                 i, vld_cnt[i], st_at5[i], st_cnt[i]);
      end
    end
    drive_op(2'd0, 32'h00010003, 32'h00020005, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== 32'h000B000F || vld_edge[i] !== 0) begin
        failures++;
        $display("FAIL mul_after_kill inst=%0d res=%h edge=%0d want 000b000f/0",
                 i, got[i], vld_edge[i]);
      end
    end
    drive_op(2'd0, 32'h00000007, 32'h00000009, 1'b1, -1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vld_cnt[i] !== 0 || res_end[i] !== 32'h000B000F) begin
        failures++;
        $display("FAIL kill_at_accept inst=%0d pulses=%0d res=%h want 0/000b000f",
                 i, vld_cnt[i], res_end[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, expv;
    M_valid = 1'b1; op_r = 2'd0;
    for (int j = 0; j < 8; j++) begin
      a = $urandom; b = $urandom;
      src1 = a; src2 = b;
      expv = a * b;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (valid[i] !== 1'b1 || res[i] !== expv || stall[i] !== 1'b0) begin
          failures++;
          $display("FAIL back_to_back op=%0d inst=%0d valid=%b res=%h stall=%b want 1/%h/0",
                   j, i, valid[i], res[i], stall[i], expv);
        end
      end
    end
    M_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid[i] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_pulse_end inst=%0d valid=%b want 0", i, valid[i]);
      end
    end
  endtask

  task automatic test_reset_mid_hh();
    src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF; op_r = 2'd1; M_valid = 1'b1;
    @(posedge clk); #1;
    M_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall[i] !== 1'b0 || valid[i] !== 1'b0 || res[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_mid_hh inst=%0d stall=%b valid=%b res=%h want 0/0/00000000",
                 i, stall[i], valid[i], res[i]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    drive_op(2'd2, 32'hFFFFFFFE, 32'h00000003, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== 32'hFFFFFFFF || vld_edge[i] !== EXP_LAT[i] || st_cnt[i] !== EXP_LAT[i]) begin
        failures++;
        $display("FAIL mulxss_after_reset inst=%0d res=%h edge=%0d stall=%0d want ffffffff/%0d/%0d",
                 i, got[i], vld_edge[i], st_cnt[i], EXP_LAT[i], EXP_LAT[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mulx_cases();
    test_kill();
    test_back_to_back();
    test_reset_mid_hh();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_cpu_mul_combine.md
# nios_cpu_mul_combine

Memory-stage multiply back end for the Nios CPU. It consumes the three registered 16x16 partial products from the multiply cell: p1 = a_lo*b_lo, p2 = a_lo*b_hi, p3 = a_hi*b_lo. It sums them into the 32-bit MUL result. For MULXUU/MULXSS/MULXSU it also computes the missing a_hi*b_hi product iteratively, applies signed corrections and delivers the high word, stalling the pipeline while busy.

## Interface
Parameters:
- HH_BITS, default 1: multiplier bits retired per iteration cycle; legal values 1, 2, 4. The iteration takes 16/HH_BITS cycles.

Ports:
- clk  in  1  CPU clock
- reset  in  1  asynchronous, active-high reset
- M_en  in  1  M-stage advance enable; the same enable that clocks the multiply cell
- M_valid  in  1  a multiply op is in M and its partial products are valid
- M_op  in  2  0 MUL, 1 MULXUU, 2 MULXSS, 3 MULXSU
- M_src1  in  32  operand a, aligned with the partial products
- M_src2  in  32  operand b, aligned with the partial products
- M_mul_cell_p1  in  32  a[15:0]*b[15:0], unsigned
- M_mul_cell_p2  in  32  a[15:0]*b[31:16], unsigned
- M_mul_cell_p3  in  32  a[31:16]*b[15:0], unsigned
- M_kill  in  1  pipeline flush; aborts the pending or in-flight op
- M_mul_stall  out  1  block busy; upstream holds M_en low
- W_mul_result  out  32  result word
- W_mul_valid  out  1  one-cycle pulse qualifying W_mul_result

## Operation
- Accept condition: M_valid & M_en & ~M_kill & state==IDLE. Inputs are ignored at all other times.
- MUL:
  - W_mul_result = (p1 + ((p2 + p3) << 16)) mod 2^32.
  - Registered at the accept edge. No stall.
- MULX*, at accept:
  - Latch a_hi, b_hi, op, a[31], b[31], a, b.
  - Latch mid = p1[31:16] + p2[15:0] + p3[15:0] (18 bits).
  - Latch side = p2[31:16] + p3[31:16] + mid[17:16] (18 bits).
  - Go to HH.
- HH: the sub-module computes hh = a_hi*b_hi by shift-add, HH_BITS bits per cycle, for 16/HH_BITS cycles. Then go to FIX.
- FIX:
  - hi_u = hh + side (mod 2^32).
  - MULXUU: hi = hi_u.
  - MULXSU: hi = hi_u − (a[31] ? b : 0).
  - MULXSS: hi = hi_u − (a[31] ? b : 0) − (b[31] ? a : 0).
  - All arithmetic mod 2^32. Register hi into W_mul_result, pulse W_mul_valid, return to IDLE.
- States: IDLE → HH (MULX accept) → FIX (last iteration) → IDLE.
- M_mul_stall = (state != IDLE), driven from the state register with no combinational path from inputs.
- M_kill while in HH or FIX: return to IDLE at the next edge with no valid pulse.
- M_kill together with an accept in IDLE: the op is dropped.
- W_mul_result holds its last value between pulses.

## Timing
- Reset values: state IDLE, W_mul_result 0, W_mul_valid 0, M_mul_stall 0, iteration counter 0.
- MUL: accept at edge t, so W_mul_valid=1 in the cycle after t. Back-to-back MULs give one result per cycle.
- MULX accepted at edge t:
  - HH occupies edges t+1 .. t+16/HH_BITS.
  - FIX writes the result at edge t+16/HH_BITS+1.
  - W_mul_valid is high for the single cycle after that edge.
- With HH_BITS=1, M_mul_stall is high for exactly 17 cycles and valid follows 17 edges after accept.
- A new op can be accepted in the first cycle that M_mul_stall is low.
- Reset asserted mid-operation: all state clears immediately and no valid pulse is produced.

## Structure
- Package nios_cpu_mul_pkg holds:
  - the mul_op_t enum: MUL, MULXUU, MULXSS, MULXSU;
  - the state enum: IDLE, HH, FIX;
  - the iteration-count width constant derived from HH_BITS.
- Sub-module nios_cpu_mul_hh_iter is an iterative 16x16 unsigned multiplier.
  - Ports: start, operands, done, product.
  - Parameter: HH_BITS.
- Summation, sign correction and the FSM stay in the top block.

## Test plan
- MUL, a=0x00010003, b=0x00020005 (p1=15, p2=6, p3=5) → W_mul_result=0x000B000F, valid the cycle after accept, stall never high.
- MULXUU, a=b=0xFFFFFFFF (HH_BITS=1) → stall high 17 cycles, result=0xFFFFFFFE, valid 17 edges after accept.
- MULXSS, a=b=0xFFFFFFFF → result=0x00000000.
- MULXSU, a=b=0xFFFFFFFF → result=0xFFFFFFFF.
- MULXUU, a=0x00010003, b=0x00020005 → result=0x00000002.
- MULXUU started, M_kill at the 5th HH cycle → no valid pulse, stall low next cycle, a following MUL is accepted and completes normally.
- 8 back-to-back MULs with random operands → 8 consecutive valid pulses matching the reference low words.
- Reset mid-HH → outputs zero, then a fresh MULXSS completes correctly.
- Sweep HH_BITS=1, 2, 4 → stall lengths 17/9/5 cycles, identical results.
